instr_encoder: RTL
==================

# instr_encoder

Instruction-stream writer for the extended MIPS core. It accepts symbolic instruction requests over a valid/ready handshake and encodes them into 32-bit words using the same opcode/funct assignments the core's control decoder recognises. It buffers the words in a small FIFO and writes them sequentially into instruction memory from a programmable base address. It is used by the boot/test loader to fill instruction memory before the core is released.

## Interface
- ADDR_W, 8, imem word-address width
- DEPTH, 4, FIFO depth in words (power of two, ≥2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load session (IDLE only)
- base_addr  in  ADDR_W  first word address, sampled with start
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready at a rising edge
- req_kind  in  4  instruction kind (package enum)
- req_rs / req_rt / req_rd  in  5 each  register fields
- req_imm  in  16  immediate/offset
- req_funct  in  6  funct, used only for K_RTYPE
- req_last  in  1  marks final request of the session
- imem_stall  in  1  memory busy; suppresses the write this cycle
- imem_we  out  1  write strobe (registered)
- imem_addr  out  ADDR_W  write address (registered)
- imem_wdata  out  32  encoded word (registered)
- done  out  1  one-cycle pulse after the last word is written
- wrapped  out  1  sticky; write address rolled past all-ones
- err  out  1  one-cycle pulse on illegal kind (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE: start → RUN; address counter := base_addr; wrapped := 0.
  - RUN: req_ready = FIFO not full. An accepted request is encoded and pushed. An accepted req_last → DRAIN.
  - DRAIN: req_ready = 0. When FIFO is empty and no write is pending, done pulses → IDLE.
- start outside IDLE is ignored. req_ready = 0 in IDLE.
- Encoding: I-format {op,rs,rt,imm}; R-format {6'b0,rs,rt,rd,5'b0,funct}.
  - K_LW op 0x23; K_SW 0x2B; K_BEQ 0x04; K_BMEM 0x14; K_JS 0x13; K_JZ 0x1A.
  - K_RTYPE uses req_funct. K_SHIFT funct 0x04; K_PCTOREG funct 0x16; K_JMEM funct 0x2D.
- Write: each cycle the FIFO is non-empty and imem_stall = 0, pop one word. Drive imem_we/addr/wdata for the next cycle, then increment the counter mod 2^ADDR_W.
- Wrap: on the write at address all-ones, set wrapped; the next address is 0. The session continues.
- Simultaneous push and pop on a full FIFO is allowed; occupancy is unchanged.

## Timing
- Reset values: state IDLE, FIFO empty, counter 0, req_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, done 0, wrapped 0, err 0.
- Latency: a request accepted at edge k into an empty FIFO, with no stall, gives imem_we = 1 between edges k+1 and k+2. Memory captures the word at edge k+2.
- Throughput: 1 word/cycle when there is no stall.
- imem_stall high holds the FIFO; imem_we is 0 in the following cycle. Requests keep filling up to DEPTH.
- done is asserted in the cycle after the last imem_we cycle.
- Reset mid-session: immediate return to reset values. Buffered words are discarded and never written.

## Configuration
- INSTR_ENCODER_CHECK_EN defined:
  - kind values outside the enum are accepted but not pushed; err pulses in the cycle after acceptance.
  - An illegal req_last still moves the block to DRAIN.
- Undefined: illegal kinds are encoded as 32'h0 (NOP) and written normally; err is tied 0.

## Structure
- Package instr_enc_pkg holds:
  - kind enum: K_RTYPE=0, K_LW=1, K_SW=2, K_BEQ=3, K_BMEM=4, K_JS=5, K_JZ=6, K_JMEM=7, K_PCTOREG=8, K_SHIFT=9;
  - opcode and funct constants, shared with the control decoder;
  - state enum.
- Sub-module instr_fifo: synchronous FIFO, width 32, parameter DEPTH, push/pop/full/empty.
- The encoder is a combinational function in the top module.

## Test plan
- base_addr=0x10, one K_LW rs=8 rt=9 imm=0x0008 with req_last → imem_addr 0x10, wdata 0x8D090008; done one cycle after the write.
- K_SW rs=8 rt=9 imm=8, then K_BEQ rs=1 rt=2 imm=0xFFFF → consecutive writes 0xAD090008 @base, 0x1022FFFF @base+1.
- K_SHIFT rs=3 rt=4 rd=5, then K_JMEM rs=31 → 0x00642804, 0x03E0002D.
- imem_stall held high 6 cycles while streaming 6 requests → req_ready drops after 4 are buffered; after release, writes resume in order with no loss and no duplicates.
- base_addr=0xFE, 3 requests → addresses 0xFE, 0xFF, 0x00; wrapped = 1 from the 0xFF write onward.
- Reset asserted with 3 words buffered → no further imem_we, all outputs at reset values. With the macro defined, req_kind=15 → err pulse and no write.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction-stream writer: instruction kinds,
// opcode/funct assignments matching the core's control decoder, and FSM states.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    K_RTYPE   = 4'd0,
    K_LW      = 4'd1,
    K_SW      = 4'd2,
    K_BEQ     = 4'd3,
    K_BMEM    = 4'd4,
    K_JS      = 4'd5,
    K_JZ      = 4'd6,
    K_JMEM    = 4'd7,
    K_PCTOREG = 4'd8,
    K_SHIFT   = 4'd9
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BMEM  = 6'h14;
  localparam logic [5:0] OP_JS    = 6'h13;
  localparam logic [5:0] OP_JZ    = 6'h1A;

  localparam logic [5:0] FN_SHIFT   = 6'h04;
  localparam logic [5:0] FN_PCTOREG = 6'h16;
  localparam logic [5:0] FN_JMEM    = 6'h2D;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic logic kind_legal(input logic [3:0] kind);
    return (kind <= 4'd9);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Symbolic instruction request channel: the loader is master, the encoder slave.
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_kind;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [15:0] req_imm;
  logic [5:0]  req_funct;
  logic        req_last;

  modport master (
    output req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, req_funct, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, req_funct, req_last,
    output req_ready
  );
endinterface

// File: rtl/instr_encoder_fifo.sv
// Synchronous word FIFO between the encoder and the imem write port.
// Accepts a push on a full FIFO when a pop happens in the same cycle.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full    = (count_r == (PW+1)'(DEPTH));
  assign empty   = (count_r == '0);
  assign rd_en_s = pop && !empty;
  assign wr_en_s = push && (!full || rd_en_s);
  assign rdata   = mem_r[rd_ptr_r];

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests and streams them into imem from base_addr.
// Optional illegal-kind trapping: define INSTR_ENCODER_CHECK_EN.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    req,
  input  logic              imem_stall,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              wrapped,
  output logic              err
);

  state_e            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              err_set_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [31:0]       enc_word_s;
  logic [31:0]       fifo_head_s;

  function automatic logic [31:0] encode(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [5:0]  funct
  );
    logic [31:0] word;
    case (kind)
      K_RTYPE:   word = {OP_RTYPE, rs, rt, rd, 5'b0, funct};
      K_SHIFT:   word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_SHIFT};
      K_PCTOREG: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_PCTOREG};
      K_JMEM:    word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_JMEM};
      K_LW:      word = {OP_LW,   rs, rt, imm};
      K_SW:      word = {OP_SW,   rs, rt, imm};
      K_BEQ:     word = {OP_BEQ,  rs, rt, imm};
      K_BMEM:    word = {OP_BMEM, rs, rt, imm};
      K_JS:      word = {OP_JS,   rs, rt, imm};
      K_JZ:      word = {OP_JZ,   rs, rt, imm};
      default:   word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  // Request encoding for the word about to be pushed.
  always_comb begin
    enc_word_s = encode(req.req_kind, req.req_rs, req.req_rt, req.req_rd,
                        req.req_imm, req.req_funct);
  end

  assign req.req_ready = (state_r == S_RUN) && !fifo_full_s;
  assign accept_s      = req.req_valid && req.req_ready;
  assign pop_s         = !fifo_empty_s && !imem_stall;

`ifdef INSTR_ENCODER_CHECK_EN
  assign push_s    = accept_s && kind_legal(req.req_kind);
  assign err_set_s = accept_s && !kind_legal(req.req_kind);
`else
  assign push_s    = accept_s;
  assign err_set_s = 1'b0;
`endif

  instr_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (enc_word_s),
    .pop   (pop_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Session FSM, address counter and registered imem/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      addr_r     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      done       <= 1'b0;
      wrapped    <= 1'b0;
      err        <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= err_set_s;
      imem_we <= pop_s;
      if (pop_s) begin
        imem_addr  <= addr_r;
        imem_wdata <= fifo_head_s;
        addr_r     <= addr_r + 1'b1;
        if (&addr_r) wrapped <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          // FIFO is always empty here, so no pop competes with the reload.
          if (start) begin
            state_r <= S_RUN;
            addr_r  <= base_addr;
            wrapped <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept_s && req.req_last) state_r <= S_DRAIN;
        end
        S_DRAIN: begin
          if (fifo_empty_s) begin
            done    <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule
